// File: rtl/dv_iter_unit.sv
// dv_iter_unit: iterative one's-complement divide engine for the DV extracode.
// Divides the double-length dividend (dividend_hi:dividend_lo) by divisor
// with a restoring shift/subtract loop, one quotient bit per cycle.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high; aborts any operation
//   start        one-cycle request, accepted only when idle
//   dividend_hi  A register (one's complement)
//   dividend_lo  L register (one's complement)
//   divisor      G register (one's complement)
//   busy         high from the accepting edge until done
//   done         one-cycle completion pulse
//   quotient     signed quotient, held until the next accepted start
//   remainder    signed remainder, held until the next accepted start
//   overflow     quotient not representable (includes divide by +/-0)
module dv_iter_unit #(
    parameter int WORD_W = 15,
    parameter int ITER   = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] dividend_hi,
    input  logic [WORD_W-1:0] dividend_lo,
    input  logic [WORD_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] quotient,
    output logic [WORD_W-1:0] remainder,
    output logic              overflow
);

    localparam int MAG_W = WORD_W - 1;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIN
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] op_hi;
    logic [WORD_W-1:0] op_lo;
    logic [WORD_W-1:0] op_div;
    logic [MAG_W-1:0]  div_mag;
    logic [MAG_W-1:0]  rem;
    logic [MAG_W-1:0]  shift;
    logic [MAG_W-1:0]  q_mag;
    logic              q_sign;
    logic              r_sign;
    logic              ovf_pend;
    logic [CNT_W-1:0]  cnt;

    // Magnitude of a one's-complement word; both zeros map to 0.
    function automatic logic [MAG_W-1:0] mag_of(input logic [WORD_W-1:0] x);
        return x[WORD_W-1] ? ~x[MAG_W-1:0] : x[MAG_W-1:0];
    endfunction

    // Negative results are the bitwise inverse of the magnitude (-0 allowed).
    function automatic logic [WORD_W-1:0] apply_sign(input logic s,
                                                     input logic [MAG_W-1:0] m);
        return s ? {1'b1, ~m} : {1'b0, m};
    endfunction

    logic [MAG_W-1:0]  hi_m;
    logic [MAG_W-1:0]  lo_m;
    logic [MAG_W-1:0]  dv_m;
    logic              div_sign;
    logic [WORD_W-1:0] rem_sh;
    logic              ge;
    logic [MAG_W-1:0]  rem_nxt;

    always_comb begin
        hi_m     = mag_of(op_hi);
        lo_m     = mag_of(op_lo);
        dv_m     = mag_of(op_div);
        // The low word's sign only matters when the high word is +/-0.
        div_sign = (hi_m == '0) ? op_lo[WORD_W-1] : op_hi[WORD_W-1];
        rem_sh   = {rem, shift[MAG_W-1]};
        ge       = rem_sh >= {1'b0, div_mag};
        // rem_sh - div_mag < div_mag when ge, so the top bit of the
        // difference is always zero and modulo-2^MAG_W arithmetic suffices.
        rem_nxt  = ge ? (rem_sh[MAG_W-1:0] - div_mag) : rem_sh[MAG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            op_hi     <= '0;
            op_lo     <= '0;
            op_div    <= '0;
            div_mag   <= '0;
            rem       <= '0;
            shift     <= '0;
            q_mag     <= '0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            ovf_pend  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // The done cycle is also idle; a start there is dropped.
                    if (start && !done) begin
                        op_hi    <= dividend_hi;
                        op_lo    <= dividend_lo;
                        op_div   <= divisor;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    q_sign  <= div_sign ^ op_div[WORD_W-1];
                    r_sign  <= div_sign;
                    div_mag <= dv_m;
                    if (hi_m >= dv_m) begin
                        ovf_pend <= 1'b1;
                        state    <= S_FIN;
                    end else begin
                        ovf_pend <= 1'b0;
                        rem      <= hi_m;
                        shift    <= lo_m;
                        q_mag    <= '0;
                        cnt      <= CNT_W'(ITER - 1);
                        state    <= S_ITER;
                    end
                end
                S_ITER: begin
                    rem   <= rem_nxt;
                    shift <= {shift[MAG_W-2:0], 1'b0};
                    q_mag <= {q_mag[MAG_W-2:0], ge};
                    if (cnt == '0) begin
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIN: begin
                    if (ovf_pend) begin
                        quotient  <= apply_sign(q_sign, '1);
                        remainder <= op_lo;
                        overflow  <= 1'b1;
                    end else begin
                        quotient  <= apply_sign(q_sign, q_mag);
                        remainder <= apply_sign(r_sign, rem);
                        overflow  <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dv_iter_unit.sv
module tb_dv_iter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] dividend_hi;
    logic [14:0] dividend_lo;
    logic [14:0] divisor;
    logic        busy;
    logic        done;
    logic [14:0] quotient;
    logic [14:0] remainder;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [14:0] q;
        logic [14:0] r;
        logic        o;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dv_iter_unit #(.WORD_W(15), .ITER(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend_hi(dividend_hi),
        .dividend_lo(dividend_lo),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer division of the 28-bit magnitude.
    function automatic exp_t model(input logic [14:0] hi, input logic [14:0] lo,
                                   input logic [14:0] dv);
        exp_t        e;
        logic [13:0] mh, ml, md;
        logic [27:0] num, qq, rr;
        logic        ds, qs;
        mh  = hi[14] ? ~hi[13:0] : hi[13:0];
        ml  = lo[14] ? ~lo[13:0] : lo[13:0];
        md  = dv[14] ? ~dv[13:0] : dv[13:0];
        ds  = (mh == 14'd0) ? lo[14] : hi[14];
        qs  = ds ^ dv[14];
        if (mh >= md) begin
            e.q   = qs ? 15'h4000 : 15'h3FFF;
            e.r   = lo;
            e.o   = 1'b1;
            e.lat = 2;
        end else begin
            num   = {mh, ml};
            qq    = num / {14'd0, md};
            rr    = num % {14'd0, md};
            e.q   = qs ? {1'b1, ~qq[13:0]} : {1'b0, qq[13:0]};
            e.r   = ds ? {1'b1, ~rr[13:0]} : {1'b0, rr[13:0]};
            e.o   = 1'b0;
            e.lat = 16;
        end
        return e;
    endfunction

    // One operation: push expectation, pulse start, wait for done, compare.
    // poke: pulse start again while busy. late: pulse start in the done cycle.
    task automatic run_op(input string tag, input logic [14:0] hi, input logic [14:0] lo,
                          input logic [14:0] dv, input bit poke, input bit late);
        exp_t e;
        int   lat;
        int   extra;
        exp_q.push_back(model(hi, lo, dv));
        @(negedge clk);
        dividend_hi = hi;
        dividend_lo = lo;
        divisor     = dv;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        dividend_hi = 15'($urandom);
        dividend_lo = 15'($urandom);
        divisor     = 15'($urandom);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 1) start = 1'b1;
            if (poke && lat == 2) start = 1'b0;
        end
        e = exp_q.pop_front();
        check({tag, ".done_seen"}, 32'(done), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(e.lat));
        check({tag, ".quotient"}, 32'(quotient), 32'(e.q));
        check({tag, ".remainder"}, 32'(remainder), 32'(e.r));
        check({tag, ".overflow"}, 32'(overflow), 32'(e.o));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        if (late) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".hold_q"}, 32'(quotient), 32'(e.q));
        if (late) check({tag, ".late_start_ignored"}, 32'(busy), 32'd0);
        if (poke || late) begin
            extra = 0;
            repeat (20) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check({tag, ".no_second_op"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        dividend_hi = '0;
        dividend_lo = '0;
        divisor     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        check("rst.q", 32'(quotient), 32'd0);
        check("rst.r", 32'(remainder), 32'd0);

        run_op("d100_7", 15'h0000, 15'd100, 15'd7, 1'b0, 1'b0);

        // Reset in the 8th iteration cycle of a running divide.
        @(negedge clk);
        dividend_hi = 15'h0000;
        dividend_lo = 15'd100;
        divisor     = 15'd7;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.q", 32'(quotient), 32'd0);
        check("midrst.r", 32'(remainder), 32'd0);
        check("midrst.ovf", 32'(overflow), 32'd0);

        run_op("d100_m7", 15'h0000, 15'd100, 15'h7FF8, 1'b0, 1'b0);
        run_op("d2p14_3", 15'd1, 15'h0000, 15'd3, 1'b0, 1'b0);
        run_op("ovf_5_5", 15'd5, 15'd9, 15'd5, 1'b0, 1'b1);
        run_op("dbz_m0", 15'h0000, 15'd4, 15'h7FFF, 1'b0, 1'b0);
        run_op("ovf_clear", 15'h0000, 15'd50, 15'd9, 1'b1, 1'b0);
        run_op("neg_lo_sign", 15'h7FFF, ~15'd100, 15'd7, 1'b0, 1'b0);
        run_op("big", 15'h1234, 15'h2BCD, 15'h3FFF, 1'b0, 1'b0);
        run_op("negneg", 15'h7FFE, 15'h5555, 15'h4000, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rnd%0d", i), 15'($urandom), 15'($urandom),
                   15'($urandom), 1'b0, 1'b0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dv_iter_unit.md
Name: dv_iter_unit

Overview:
- Iterative one's-complement divide engine for the DV extracode.
- Sits directly downstream of the control unit. The control unit hands it the double-precision dividend (A:L) and the divisor (G), then writes the returned quotient to A and the remainder to L.
- Uses a start/busy/done handshake, a 14-step restoring-division datapath and an overflow/divide-by-zero detector.
- The control unit stalls its write-back timing pulses until done is asserted.

Parameters:
- WORD_W, 15, word width including the sign bit (bit WORD_W-1); magnitude is WORD_W-1 bits.
- ITER, 14, number of quotient bits; must equal WORD_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; returns the block to IDLE.
- start  input  1  one-cycle request; sampled only while busy=0.
- dividend_hi  input  15  A register, one's complement.
- dividend_lo  input  15  L register, one's complement.
- divisor  input  15  G register, one's complement.
- busy  output  1  high from the edge after start is accepted until done.
- done  output  1  one-cycle pulse; outputs below are valid while done=1 and held until the next accepted start.
- quotient  output  15  one's-complement quotient, written to A by the control unit.
- remainder  output  15  one's-complement remainder, written to L by the control unit.
- overflow  output  1  set when the quotient is not representable, including divide by ±0.

Behaviour:
- Reset: state=IDLE; busy, done, overflow=0; quotient, remainder=15'h0000; iteration counter=0. Reset in any state aborts the operation and sets done=0 on the next edge.
- Magnitude: if the sign bit is 0, magnitude = x[13:0]; otherwise magnitude = ~x[13:0]. Both +0 (15'h0000) and -0 (15'h7FFF) have magnitude 0.
- Dividend sign: sign of dividend_hi, unless |dividend_hi|=0, in which case the sign of dividend_lo. The sign of dividend_lo is otherwise ignored.
- Result signs:
  - quotient sign = dividend sign XOR divisor sign.
  - remainder sign = dividend sign.
  - A negative result is the bitwise inverse of its magnitude, so -0 (15'h7FFF) is a legal output.
- State machine (IDLE, LOAD, ITER, FIN):
  - IDLE: when start=1 on edge k, latch the three operands and go to LOAD. busy=1 after edge k.
  - LOAD: compute the magnitudes.
    - If |hi| >= |divisor|, including |divisor|=0: go to FIN with ovf=1.
    - Otherwise: rem (15 bits) = {0,|hi|}, shift = |lo|, cnt=13, go to ITER.
  - ITER, each cycle:
    - rem' = {rem[13:0], shift[13]}; shift <<= 1.
    - If rem' >= |divisor|: rem = rem' - |divisor| and qbit=1; else rem = rem' and qbit=0.
    - Shift qbit into the quotient magnitude LSB-first-in.
    - Go to FIN when cnt=0, otherwise decrement cnt.
    - Invariant: rem < |divisor|, so no overflow of the 15-bit rem.
  - FIN: drive quotient and remainder with signs applied, set overflow, pulse done=1 for one cycle, busy=0, return to IDLE.
- Overflow result: quotient = sign-applied magnitude 14'h3FFF (15'h3FFF positive, 15'h4000 negative); remainder = dividend_lo unchanged; overflow=1.
- Latency:
  - Normal path: done=1 after edge k+16 (LOAD 1 cycle + ITER 14 cycles + FIN 1 cycle).
  - Overflow path: done=1 after edge k+2.
- start while busy=1 is ignored; operands are not relatched. start on the same edge that done deasserts (FIN->IDLE) is ignored; start is accepted only when state=IDLE.
- overflow is cleared when the next start is accepted.
- Operand inputs may change freely after the accepting edge.

Test Plan:
- Reset mid-ITER (cycle 8 of 14) -> busy=0, done=0, quotient=0, remainder=0, overflow=0 on the next edge; a new start then completes normally.
- hi=15'h0000, lo=15'd100, divisor=15'd7 -> done after exactly 16 cycles; quotient=15'd14, remainder=15'd2, overflow=0.
- hi=15'h0000, lo=15'd100, divisor=15'h7FF8 (-7) -> quotient=15'h7FF1 (-14), remainder=15'd2.
- hi=15'd1, lo=15'h0000, divisor=15'd3 -> quotient=15'h1555 (5461), remainder=15'd1.
- hi=15'd5, lo=15'd9, divisor=15'd5 -> done after 2 cycles, overflow=1, quotient=15'h3FFF, remainder=15'd9.
- Divide by zero with hi=15'h0000, lo=15'd4, divisor=15'h7FFF (-0) -> overflow=1, quotient=15'h4000. A start pulse asserted while busy=1 produces no second done pulse.
